debug_dump_uart_tx: RTL and testbench

- Host-side reader for the single-cycle core's debug port.
- On a start pulse it snapshots PC, then walks the debug source select through registers 0..NUM_REGS-1, capturing one debug word per index.
- Streams a framed dump out on a UART 8N1 TX line to the lab PC.
- Sits beside the core on the FPGA top and owns the core's debug select input.

---
 rtl/debug_dump_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_debug_dump_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_uart_tx.sv
// Debug-port dump streamer: snapshots PC, walks debug_sel, sends 8N1 frame.
// Optional trailing XOR checksum byte: define DEBUG_DUMP_CHECKSUM_EN.
module debug_dump_uart_tx #(
    parameter int          CLKS_PER_BIT  = 434,
    parameter int          NUM_REGS      = 32,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_in,
    input  logic [31:0] debug_word,
    output logic [4:0]  debug_sel,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        SELECT,
        SETTLE,
        WORD,
`ifdef DEBUG_DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q;
    logic [3:0]      bit_q;
    logic [1:0]      byte_q;
    logic [SW-1:0]   settle_q;
    logic [4:0]      idx_q;
    logic [31:0]     shift_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    logic            sending;
    logic            bit_end;
    logic            byte_end;
    logic            last_byte;
    logic            last_reg;
    logic            settle_last;
    logic [7:0]      cur_byte;
    logic [2:0]      bit_idx;

    always_comb begin
        sending = (state_q == HDR) || (state_q == PC) || (state_q == WORD);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (state_q == CSUM) sending = 1'b1;
`endif
    end

    assign bit_end     = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign byte_end    = sending && bit_end && (bit_q == 4'd9);
    assign last_byte   = (byte_q == 2'd3);
    assign last_reg    = (idx_q == 5'(NUM_REGS - 1));
    assign settle_last = (settle_q == SW'(SETTLE_CYCLES - 1));
    assign bit_idx     = 3'(bit_q - 4'd1);

    always_comb begin
        cur_byte = shift_q[31:24];
        if (state_q == HDR) cur_byte = SYNC_BYTE;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (state_q == CSUM) cur_byte = csum_q;
`endif
    end

    // Start bit at bit 0, stop bit at bit 9, data LSB first between.
    always_comb begin
        tx = 1'b1;
        if (sending) begin
            if (bit_q == 4'd0)      tx = 1'b0;
            else if (bit_q != 4'd9) tx = cur_byte[bit_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = HDR;
            HDR:    if (byte_end) state_d = PC;
            PC:     if (byte_end && last_byte) state_d = SELECT;
            SELECT: state_d = SETTLE;
            SETTLE: if (settle_last) state_d = WORD;
            WORD: begin
                if (byte_end && last_byte) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    state_d = last_reg ? CSUM : SELECT;
`else
                    state_d = last_reg ? DONE : SELECT;
`endif
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            CSUM:   if (byte_end) state_d = DONE;
`endif
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            if (sending) begin
                if (bit_end) begin
                    baud_q <= '0;
                    bit_q  <= (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
                end else begin
                    baud_q <= baud_q + BW'(1);
                end
            end else begin
                baud_q <= '0;
                bit_q  <= '0;
            end

            if (state_q == IDLE && start) begin
                shift_q <= pc_in;
                idx_q   <= '0;
                byte_q  <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_q  <= '0;
`endif
            end

            if ((state_q == PC || state_q == WORD) && byte_end) begin
                shift_q <= {shift_q[23:0], 8'h00};
                byte_q  <= byte_q + 2'd1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                csum_q  <= csum_q ^ shift_q[31:24];
`endif
            end

            // Index wraps to 0 on the last word so debug_sel is 0 in DONE.
            if (state_q == WORD && byte_end && last_byte)
                idx_q <= last_reg ? 5'd0 : idx_q + 5'd1;

            if (state_q == SETTLE) begin
                settle_q <= settle_last ? '0 : settle_q + SW'(1);
                if (settle_last) shift_q <= debug_word;
            end

            if (state_q == DONE) idx_q <= '0;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign debug_sel = idx_q;

endmodule

// File: tb/tb_debug_dump_uart_tx.sv
// Directed bench for debug_dump_uart_tx: decodes the tx line cycle by cycle
// and checks bytes, bit timing, gaps, busy/done and debug_sel sequencing.
module tb_debug_dump_uart_tx;

    localparam int CPB = 4;
    localparam int NR  = 2;
    localparam int SC  = 2;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int NB  = 6 + 4 * NR;
`else
    localparam int NB  = 5 + 4 * NR;
`endif
    localparam int MAXS = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] debug_word;
    logic [4:0]  debug_sel;
    logic        tx;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic       tx_s   [MAXS];
    logic       busy_s [MAXS];
    logic       done_s [MAXS];
    logic [4:0] sel_s  [MAXS];
    int         n_samp;
    bit         got_done;

    always #5 clk = ~clk;

    always_comb begin
        debug_word = 32'h0;
        if (debug_sel == 5'd0) debug_word = 32'h1234_5678;
        if (debug_sel == 5'd1) debug_word = 32'hDEAD_BEEF;
    end

    debug_dump_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .NUM_REGS     (NR),
        .SETTLE_CYCLES(SC),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pc_in     (pc_in),
        .debug_word(debug_word),
        .debug_sel (debug_sel),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then record outputs each cycle until done (bounded).
    task automatic run_frame(input logic [31:0] pc, input int restart_at);
        pc_in = pc;
        start = 1'b1;
        step();
        start = 1'b0;
        n_samp = 0;
        got_done = 1'b0;
        for (int c = 0; c < MAXS && !got_done; c++) begin
            tx_s[c]   = tx;
            busy_s[c] = busy;
            done_s[c] = done;
            sel_s[c]  = debug_sel;
            n_samp    = c + 1;
            if (done === 1'b1) got_done = 1'b1;
            start = (c == restart_at);
            if (!got_done) step();
        end
        start = 1'b0;
        step();
    endtask

    task automatic check_frame(input logic [31:0] pc, input string tag);
        logic [7:0] exp_b [NB];
        logic [7:0] csum;
        logic [7:0] got;
        logic       lvl;
        int end_pos [NB];
        int pos, gap, bad, exp_gap, dcnt, bbad;
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            exp_b[1 + i] = pc[31 - 8 * i -: 8];
            exp_b[5 + i] = 8'h12 + 8'h22 * 8'(i);
        end
        exp_b[9]  = 8'hDE;
        exp_b[10] = 8'hAD;
        exp_b[11] = 8'hBE;
        exp_b[12] = 8'hEF;
        csum = 8'h00;
        for (int i = 1; i < 13; i++) csum ^= exp_b[i];
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_b[13] = csum;
`endif
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL %s timeout: done=0 after %0d cycles, required done pulse",
                     tag, n_samp);
            return;
        end
        vectors++;
        if (tx_s[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s first_start_bit: tx=%b required 0", tag, tx_s[0]);
        end
        pos = 0;
        for (int k = 0; k < NB; k++) begin
            gap = 0;
            while (pos < n_samp && tx_s[pos] === 1'b1) begin
                gap++;
                pos++;
            end
            vectors++;
            if (pos + 10 * CPB > n_samp) begin
                miscompares++;
                $display("FAIL %s byte%0d truncated: at %0d of %0d, required 40 cycles",
                         tag, k, pos, n_samp);
                return;
            end
            for (int b = 0; b < 8; b++) got[b] = tx_s[pos + CPB * (b + 1) + 2];
            if (got !== exp_b[k]) begin
                miscompares++;
                $display("FAIL %s byte%0d value: got %h required %h", tag, k, got, exp_b[k]);
            end
            bad = 0;
            for (int b = 0; b < 10; b++) begin
                lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[k][b - 1];
                for (int j = 0; j < CPB; j++)
                    if (tx_s[pos + CPB * b + j] !== lvl) bad++;
            end
            exp_gap = (k == 5 || k == 9) ? 1 + SC : 0;
            vectors++;
            if (bad != 0 || gap != exp_gap) begin
                miscompares++;
                $display("FAIL %s byte%0d timing: bad_cycles=%0d gap=%0d required 0 and %0d",
                         tag, k, bad, gap, exp_gap);
            end
            pos += 10 * CPB;
            end_pos[k] = pos;
        end
        vectors++;
        if (n_samp - 1 != end_pos[NB - 1] || done_s[n_samp - 1] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_pos: done at %0d required %0d", tag, n_samp - 1,
                     end_pos[NB - 1]);
        end
        dcnt = 0;
        bbad = 0;
        for (int c = 0; c < n_samp; c++) begin
            if (done_s[c] === 1'b1) dcnt++;
            if (c < n_samp - 1 && busy_s[c] !== 1'b1) bbad++;
        end
        vectors++;
        if (dcnt != 1 || bbad != 0 || busy_s[n_samp - 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_done: done_pulses=%0d busy_low=%0d busy_end=%b required 1 0 0",
                     tag, dcnt, bbad, busy_s[n_samp - 1]);
        end
        vectors++;
        if (sel_s[end_pos[8] - 1] !== 5'd0 || sel_s[end_pos[8]] !== 5'd1) begin
            miscompares++;
            $display("FAIL %s sel_switch: sel=%0d,%0d around word0 end, required 0,1",
                     tag, sel_s[end_pos[8] - 1], sel_s[end_pos[8]]);
        end
        vectors++;
        if (sel_s[n_samp - 1] !== 5'd0) begin
            miscompares++;
            $display("FAIL %s sel_done: sel=%0d required 0", tag, sel_s[n_samp - 1]);
        end
    endtask

    task automatic test_reset();
        int hi;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || debug_sel !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b sel=%0d required 1 0 0 0",
                     tx, busy, done, debug_sel);
        end
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) hi++;
            step();
        end
        vectors++;
        if (hi != 0) begin
            miscompares++;
            $display("FAIL idle_line: %0d non-idle cycles required 0", hi);
        end
    endtask

    task automatic test_frame();
        run_frame(32'h0000_0010, -1);
        check_frame(32'h0000_0010, "frame");
    endtask

    task automatic test_restart_ignored();
        run_frame(32'h0000_0010, 100);
        check_frame(32'h0000_0010, "restart");
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_after: busy=%b tx=%b required 0 1", busy, tx);
        end
    endtask

    task automatic test_reset_mid_frame();
        pc_in = 32'h0000_0010;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (60) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || debug_sel !== 5'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: tx=%b busy=%b sel=%0d done=%b required 1 0 0 0",
                     tx, busy, debug_sel, done);
        end
        repeat (5) step();
        run_frame(32'hCAFE_0004, -1);
        check_frame(32'hCAFE_0004, "after_reset");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_restart_ignored();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
